// File: rtl/lane_settle_reset_gen.sv
// lane_settle_reset_gen: filters per-lane MIPI LP indications into lane resets,
// a combined group reset, a release pulse and a sticky lane-skew error.

// One lane's settle filter: HOLD until lp drops, SETTLE for HOLD_CYCLES
// consecutive low samples, then ACTIVE until lp rises again.
module lane_settle_lane #(
    parameter int HOLD_CYCLES = 11
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lp,
    output logic o_line_reset,
    output logic o_active
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_line_reset;

    // Lane FSM with registered reset output; any lp=1 sample drops back to HOLD.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_HOLD;
            r_cnt        <= '0;
            r_line_reset <= 1'b1;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_line_reset <= 1'b1;
                    if (!i_lp) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= CW'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (i_lp) begin
                        // a glitch restarts settling from scratch
                        r_state      <= S_HOLD;
                        r_cnt        <= '0;
                        r_line_reset <= 1'b1;
                    end else if (r_cnt == C_LAST) begin
                        // count holds at its last value; it never wraps
                        r_state      <= S_ACTIVE;
                        r_line_reset <= 1'b0;
                    end else begin
                        r_cnt        <= r_cnt + CW'(1);
                        r_line_reset <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (i_lp) begin
                        r_state      <= S_HOLD;
                        r_cnt        <= '0;
                        r_line_reset <= 1'b1;
                    end else begin
                        r_line_reset <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_HOLD;
                    r_cnt        <= '0;
                    r_line_reset <= 1'b1;
                end
            endcase
        end
    end

    assign o_line_reset = r_line_reset;
    assign o_active     = (r_state == S_ACTIVE);

endmodule

// Top: per-lane filters, group reset, release pulse and skew monitor.
module lane_settle_reset_gen #(
    parameter int LANES       = 4,
    parameter int HOLD_CYCLES = 11,
    parameter int SKEW_MAX    = 64,
    parameter int GROUP_ALL   = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [LANES-1:0] lp_data_i,
    input  logic             clear_err_i,
    output logic [LANES-1:0] line_reset_o,
    output logic             group_reset_o,
    output logic             settle_pulse_o,
    output logic             skew_err_o
);
    localparam int SW = $clog2(SKEW_MAX + 1);
    localparam logic [SW-1:0] C_SKEW_MAX = SW'(SKEW_MAX);

    logic [LANES-1:0] w_line;
    logic [LANES-1:0] w_active;
    logic             w_group;
    logic             w_disagree;

    logic             r_group_q;
    logic             r_pulse;
    logic [SW-1:0]    r_skew_cnt;
    logic             r_err;

    lane_settle_lane #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_lane [LANES-1:0] (
        .i_clk        (clk_i),
        .i_rst        (reset_i),
        .i_lp         (lp_data_i),
        .o_line_reset (w_line),
        .o_active     (w_active)
    );

    generate
        if (GROUP_ALL != 0) begin : g_grp_all
            assign w_group = |w_line;
        end else begin : g_grp_l0
            assign w_group = w_line[0];
        end
        // A single lane can never disagree with itself.
        if (LANES > 1) begin : g_skew
            assign w_disagree = (|w_active) & ~(&w_active);
        end else begin : g_noskew
            assign w_disagree = 1'b0;
        end
    endgenerate

    // Release pulse: one cycle after the group reset falls.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_group_q <= 1'b1;
            r_pulse   <= 1'b0;
        end else begin
            r_group_q <= w_group;
            r_pulse   <= r_group_q & ~w_group;
        end
    end

    // Skew counter: runs while lanes are split, saturates, clears when they agree.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_skew_cnt <= '0;
        end else if (!w_disagree) begin
            r_skew_cnt <= '0;
        end else if (r_skew_cnt != C_SKEW_MAX) begin
            r_skew_cnt <= r_skew_cnt + SW'(1);
        end
    end

    // Sticky error; a pending set takes priority over clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_err <= 1'b0;
        end else if (r_skew_cnt == C_SKEW_MAX) begin
            r_err <= 1'b1;
        end else if (clear_err_i) begin
            r_err <= 1'b0;
        end
    end

    assign line_reset_o   = w_line;
    assign group_reset_o  = w_group;
    assign settle_pulse_o = r_pulse;
    assign skew_err_o     = r_err;

endmodule

// File: tb/tb_lane_settle_reset_gen.sv
// Directed bench for lane_settle_reset_gen: vector table plus corner sequences.
module tb_lane_settle_reset_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] lp  = 4'hF;
    logic [3:0] lp_g0 = 4'hF;

    logic [3:0] line, line_g0;
    logic       grp, pulse, err, grp_g0, pulse_g0, err_g0;
    logic [0:0] line_l1;
    logic       grp_l1, pulse_l1, err_l1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lane_settle_reset_gen dut (
        .clk_i(clk), .reset_i(rst), .lp_data_i(lp), .clear_err_i(clr),
        .line_reset_o(line), .group_reset_o(grp),
        .settle_pulse_o(pulse), .skew_err_o(err));

    lane_settle_reset_gen #(.GROUP_ALL(0)) dut_g0 (
        .clk_i(clk), .reset_i(rst), .lp_data_i(lp_g0), .clear_err_i(clr),
        .line_reset_o(line_g0), .group_reset_o(grp_g0),
        .settle_pulse_o(pulse_g0), .skew_err_o(err_g0));

    lane_settle_reset_gen #(.LANES(1)) dut_l1 (
        .clk_i(clk), .reset_i(rst), .lp_data_i(lp[0:0]), .clear_err_i(clr),
        .line_reset_o(line_l1), .group_reset_o(grp_l1),
        .settle_pulse_o(pulse_l1), .skew_err_o(err_l1));

    typedef struct {
        logic       rst;
        logic [3:0] lp;
        logic       clr;
        int         n;
        logic [3:0] line;
        logic       grp;
        logic       pulse;
        logic       err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic [3:0] l, logic c, int n,
                                logic [3:0] el, logic eg, logic ep, logic ee);
        vec_t v;
        v.rst = r; v.lp = l; v.clr = c; v.n = n;
        v.line = el; v.grp = eg; v.pulse = ep; v.err = ee;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %h, want %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        // release from edge N; all lanes free after edge N+10, pulse after N+11
        vt.push_back(mk(1, 4'hF, 0, 1,  4'hF, 1, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 1,  4'hF, 1, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 9,  4'hF, 1, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 1,  4'h0, 0, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 1,  4'h0, 0, 1, 0));
        vt.push_back(mk(0, 4'h0, 0, 1,  4'h0, 0, 0, 0));
        // lane 1 drops into LP for one cycle while active
        vt.push_back(mk(0, 4'h2, 0, 1,  4'h2, 1, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 10, 4'h2, 1, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 1,  4'h0, 0, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 1,  4'h0, 0, 1, 0));
        vt.push_back(mk(0, 4'h0, 0, 1,  4'h0, 0, 0, 0));
        // lane 2 glitches at settle count 7, restarts
        vt.push_back(mk(1, 4'hF, 0, 1,  4'hF, 1, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 7,  4'hF, 1, 0, 0));
        vt.push_back(mk(0, 4'h4, 0, 1,  4'hF, 1, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 3,  4'h4, 1, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 7,  4'h4, 1, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 1,  4'h0, 0, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 1,  4'h0, 0, 1, 0));
        // lane 3 held in LP: skew error, clear blocked, then cleared
        vt.push_back(mk(1, 4'hF, 0, 1,  4'hF, 1, 0, 0));
        vt.push_back(mk(0, 4'h8, 0, 10, 4'hF, 1, 0, 0));
        vt.push_back(mk(0, 4'h8, 0, 1,  4'h8, 1, 0, 0));
        vt.push_back(mk(0, 4'h8, 0, 64, 4'h8, 1, 0, 0));
        vt.push_back(mk(0, 4'h8, 0, 1,  4'h8, 1, 0, 1));
        vt.push_back(mk(0, 4'h8, 1, 1,  4'h8, 1, 0, 1));
        vt.push_back(mk(0, 4'h0, 0, 10, 4'h8, 1, 0, 1));
        vt.push_back(mk(0, 4'h0, 0, 1,  4'h0, 0, 0, 1));
        vt.push_back(mk(0, 4'h0, 0, 1,  4'h0, 0, 1, 1));
        vt.push_back(mk(0, 4'h0, 1, 1,  4'h0, 0, 0, 0));
        vt.push_back(mk(0, 4'h0, 0, 1,  4'h0, 0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; lp = vt[i].lp; clr = vt[i].clr;
            repeat (vt[i].n) step();
            chk("line",  i, line,         vt[i].line);
            chk("group", i, 4'(grp),      4'(vt[i].grp));
            chk("pulse", i, 4'(pulse),    4'(vt[i].pulse));
            chk("err",   i, 4'(err),      4'(vt[i].err));
            chk("l1_line", i, 4'(line_l1), 4'(vt[i].line[0]));
            chk("l1_err",  i, 4'(err_l1),  4'h0);
        end
        clr = 1'b0;

        // async reset while active and pulsing: no clock edge needed
        rst = 1'b1; lp = 4'hF; step();
        rst = 1'b0; lp = 4'h0;
        repeat (11) step();
        chk("pre_rst_line", 100, line, 4'h0);
        step();
        chk("pre_rst_pulse", 101, 4'(pulse), 4'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_line",  102, line, 4'hF);
        chk("async_group", 103, 4'(grp), 4'h1);
        chk("async_pulse", 104, 4'(pulse), 4'h0);

        // async reset at settle count 5 discards progress
        rst = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("mid_settle_line", 105, line, 4'hF);
        rst = 1'b0;
        repeat (10) step();
        chk("resettle_hold", 106, line, 4'hF);
        step();
        chk("resettle_rel", 107, line, 4'h0);

        // lane-0-only group mode: lane 1 held does not block the group
        rst = 1'b1; step();
        rst = 1'b0; lp_g0 = 4'h2;
        repeat (10) step();
        chk("g0_group_hold", 110, 4'(grp_g0), 4'h1);
        step();
        chk("g0_line",  111, line_g0, 4'h2);
        chk("g0_group", 112, 4'(grp_g0), 4'h0);
        chk("g0_pulse0", 113, 4'(pulse_g0), 4'h0);
        step();
        chk("g0_pulse1", 114, 4'(pulse_g0), 4'h1);
        step();
        chk("g0_pulse2", 115, 4'(pulse_g0), 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
